// File: rtl/expr_eval.sv
// Streaming "num (op num)* =" evaluator mod 2^W; 1-cycle latency, in_valid gates consumption, no backpressure.
// Define EXPR_MUL_EN to accept '*' (binds tighter than '+'/'-'); otherwise '*' is an illegal character.
module expr_eval #(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic         out,
  output logic         err,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_NUM, S_OP, S_ERR} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   num_q, num_d;
  logic [W-1:0]   result_q, result_d;
  logic           sign_q, sign_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_q, out_d;
  logic           err_q, err_d;
  logic           done_q, done_d;

  logic           is_digit, is_add, is_sub, is_eq;
  logic [W-1:0]   digit_w, num_next, prod, folded;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_add   = (in == 8'h2B);
  assign is_sub   = (in == 8'h2D);
  assign is_eq    = (in == 8'h3D);
  assign digit_w  = W'(in[3:0]);
  // num*10 as shift-add so the default build has no general multiplier
  assign num_next = (num_q << 3) + (num_q << 1) + digit_w;

`ifdef EXPR_MUL_EN
  logic [W-1:0] term_q, term_d;
  logic         is_mul;
  assign is_mul = (in == 8'h2A);
  assign prod   = term_q * num_q;
`else
  assign prod   = num_q;
`endif

  assign folded = sign_q ? (acc_q - prod) : (acc_q + prod);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    num_d    = num_q;
    result_d = result_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef EXPR_MUL_EN
    term_d   = term_q;
`endif
    if (in_valid) begin
      case (state_q)
        S_IDLE, S_OP: begin
          if (is_digit) begin
            state_d = S_NUM;
            num_d   = digit_w;
            cnt_d   = CW'(1);
            if (state_q == S_IDLE) begin
              acc_d  = '0;
              sign_d = 1'b0;
`ifdef EXPR_MUL_EN
              term_d = W'(1);
`endif
            end
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            if (cnt_q == CW'(MAX_DIGITS)) begin
              state_d = S_ERR;
            end else begin
              num_d = num_next;
              cnt_d = cnt_q + CW'(1);
            end
          end else if (is_add || is_sub) begin
            state_d = S_OP;
            acc_d   = folded;
            sign_d  = is_sub;
`ifdef EXPR_MUL_EN
            term_d  = W'(1);
          end else if (is_mul) begin
            state_d = S_OP;
            term_d  = prod;
            num_d   = '0;
`endif
          end else if (is_eq) begin
            state_d  = S_IDLE;
            result_d = folded;
            done_d   = 1'b1;
            acc_d    = '0;
            num_d    = '0;
            sign_d   = 1'b0;
            cnt_d    = '0;
`ifdef EXPR_MUL_EN
            term_d   = '0;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          // sticky until '=', which restarts without producing a result
          if (is_eq) begin
            state_d = S_IDLE;
            acc_d   = '0;
            num_d   = '0;
            sign_d  = 1'b0;
            cnt_d   = '0;
`ifdef EXPR_MUL_EN
            term_d  = '0;
`endif
          end
        end
        default: state_d = S_ERR;
      endcase
    end
    out_d = (state_d == S_NUM);
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      num_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef EXPR_MUL_EN
      term_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      num_q    <= num_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      err_q    <= err_d;
      done_q   <= done_d;
`ifdef EXPR_MUL_EN
      term_q   <= term_d;
`endif
    end
  end

  assign out    = out_q;
  assign err    = err_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: directed table, corner sequences and random stream against a grammar-level model.
module tb_expr_eval;

  localparam int MD = 5;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        in_valid;
  logic [7:0]  in_c;
  logic        out, err, done;
  logic [15:0] result;
  logic        out8, err8, done8;
  logic [7:0]  result8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  expr_eval #(.W(16), .MAX_DIGITS(MD)) dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(in_c),
    .out(out), .err(err), .done(done), .result(result)
  );

  expr_eval #(.W(8), .MAX_DIGITS(MD)) dut8 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(in_c),
    .out(out8), .err(err8), .done(done8), .result(result8)
  );

  // ---------------- reference model: grammar over a character buffer ----------------
  logic [7:0]  mbuf[$];
  bit          m_err;
  bit          m_done;
  logic [63:0] m_res;

  function automatic bit isdig(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit isop(input logic [7:0] c);
`ifdef EXPR_MUL_EN
    return (c == "+") || (c == "-") || (c == "*");
`else
    return (c == "+") || (c == "-");
`endif
  endfunction

  function automatic int trailing_digits();
    int n = 0;
    for (int i = mbuf.size() - 1; i >= 0; i--) begin
      if (!isdig(mbuf[i])) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit last_is_digit();
    return (mbuf.size() > 0) && isdig(mbuf[mbuf.size() - 1]);
  endfunction

  // Sum of products with ordinary precedence; 64-bit wrap is consistent with any smaller 2^W
  function automatic logic [63:0] eval_buf();
    logic [63:0] acc = 0, prod = 1, numv = 0;
    bit neg = 0;
    foreach (mbuf[i]) begin
      if (isdig(mbuf[i])) numv = numv * 10 + 64'(mbuf[i] - 8'h30);
      else if (mbuf[i] == "*") begin prod = prod * numv; numv = 0; end
      else begin
        acc  = neg ? acc - prod * numv : acc + prod * numv;
        neg  = (mbuf[i] == "-");
        prod = 1;
        numv = 0;
      end
    end
    return neg ? acc - prod * numv : acc + prod * numv;
  endfunction

  task automatic model_step(input logic [7:0] c);
    bit bad = 0;
    m_done = 0;
    if (m_err) begin
      if (c == "=") begin m_err = 0; mbuf.delete(); end
    end else if (isdig(c)) begin
      if (last_is_digit() && trailing_digits() >= MD) bad = 1;
      else mbuf.push_back(c);
    end else if (isop(c)) begin
      if (last_is_digit()) mbuf.push_back(c);
      else bad = 1;
    end else if (c == "=" && last_is_digit()) begin
      m_res  = eval_buf();
      m_done = 1;
      mbuf.delete();
    end else begin
      bad = 1;
    end
    if (bad) begin m_err = 1; mbuf.delete(); end
  endtask

  function automatic bit m_out();
    return !m_err && last_is_digit();
  endfunction

  task automatic m_reset();
    mbuf.delete();
    m_err = 0; m_done = 0; m_res = 0;
  endtask

  // ---------------- checking and driving ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out"}, 64'(out), 64'(m_out()));
    chk({tag, ".err"}, 64'(err), 64'(m_err));
    chk({tag, ".done"}, 64'(done), 64'(m_done));
    chk({tag, ".result"}, 64'(result), 64'(m_res[15:0]));
    chk({tag, ".result8"}, 64'(result8), 64'(m_res[7:0]));
    chk({tag, ".err8"}, 64'(err8), 64'(m_err));
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    in_c     = c;
    model_step(c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic [7:0] junk);
    @(negedge clk);
    in_valid = 1'b0;
    in_c     = junk;
    m_done   = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    m_reset();
    #2;
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       s;
    bit          o;
    bit          e;
    bit          d;
    logic [15:0] r;
    logic [7:0]  r8;
  } vec_t;

  vec_t vt[$];

  initial begin
    clr_n    = 1'b0;
    in_valid = 1'b0;
    in_c     = 8'h00;

    vt.push_back('{"1+22=",     0, 0, 1, 16'd23,    8'd23});
    vt.push_back('{"1+22=7",    1, 0, 0, 16'd23,    8'd23});
    vt.push_back('{"1++",       0, 1, 0, 16'd0,     8'd0});
    vt.push_back('{"1++3=",     0, 0, 0, 16'd0,     8'd0});
    vt.push_back('{"12345",     1, 0, 0, 16'd0,     8'd0});
    vt.push_back('{"123456",    0, 1, 0, 16'd0,     8'd0});
    vt.push_back('{"5-7=",      0, 0, 1, 16'd65534, 8'd254});
    vt.push_back('{"200+100=",  0, 0, 1, 16'd300,   8'd44});
    vt.push_back('{"99999+1=",  0, 0, 1, 16'd34464, 8'd160});
    vt.push_back('{"0=",        0, 0, 1, 16'd0,     8'd0});
    vt.push_back('{"=",         0, 1, 0, 16'd0,     8'd0});
    vt.push_back('{"4x",        0, 1, 0, 16'd0,     8'd0});
    vt.push_back('{"12-",       0, 0, 0, 16'd0,     8'd0});
`ifdef EXPR_MUL_EN
    vt.push_back('{"2+3*4=",      0, 0, 1, 16'd14,    8'd14});
    vt.push_back('{"2*=",         0, 1, 0, 16'd0,     8'd0});
    vt.push_back('{"2+3*",        0, 0, 0, 16'd0,     8'd0});
    vt.push_back('{"10-2*3*4+1=", 0, 0, 1, 16'd65523, 8'd243});
`else
    vt.push_back('{"2+3*",      0, 1, 0, 16'd0,     8'd0});
`endif

    // reset state while clr_n is held low
    #3;
    chk("reset.out", 64'(out), 0);
    chk("reset.err", 64'(err), 0);
    chk("reset.done", 64'(done), 0);
    chk("reset.result", 64'(result), 0);
    #4;
    clr_n = 1'b1;
    m_reset();

    foreach (vt[i]) begin
      do_reset();
      send_str(vt[i].s);
      chk({vt[i].s, ".out"}, 64'(out), 64'(vt[i].o));
      chk({vt[i].s, ".err"}, 64'(err), 64'(vt[i].e));
      chk({vt[i].s, ".done"}, 64'(done), 64'(vt[i].d));
      chk({vt[i].s, ".result"}, 64'(result), 64'(vt[i].r));
      chk({vt[i].s, ".result8"}, 64'(result8), 64'(vt[i].r8));
    end

    // per-character view of "1+22=" and the single-cycle done pulse
    do_reset();
    send("1"); chk("seq1.out_1", 64'(out), 1);
    send("+"); chk("seq1.out_plus", 64'(out), 0);
    send("2"); chk("seq1.out_2a", 64'(out), 1);
    send("2"); chk("seq1.out_2b", 64'(out), 1);
    send("="); chk("seq1.done", 64'(done), 1); chk("seq1.err", 64'(err), 0);
    idle_cycle("9"); chk("seq1.done_drop", 64'(done), 0); chk("seq1.hold", 64'(result), 23);

    // sticky error then recovery on '='
    do_reset();
    send_str("1++"); chk("seq2.err", 64'(err), 1);
    send("5");       chk("seq2.sticky", 64'(err), 1);
    send("=");       chk("seq2.clear", 64'(err), 0); chk("seq2.nodone", 64'(done), 0);

    // asynchronous reset mid-cycle discards a partial expression and the held result
    do_reset();
    send_str("9=");
    send_str("1+");
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    m_reset();
    #1;
    chk("arst.out", 64'(out), 0);
    chk("arst.err", 64'(err), 0);
    chk("arst.done", 64'(done), 0);
    chk("arst.result", 64'(result), 0);
    #1;
    clr_n = 1'b1;
    send_str("7=");
    chk("arst.after_done", 64'(done), 1);
    chk("arst.after_result", 64'(result), 7);

    // in_valid low mid-number holds everything
    do_reset();
    send_str("12");
    for (int i = 0; i < 3; i++) begin
      idle_cycle("+");
      chk("hold.out", 64'(out), 1);
      chk("hold.err", 64'(err), 0);
      chk("hold.done", 64'(done), 0);
    end
    send_str("3=");
    chk("hold.result", 64'(result), 123);

    // random character stream against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        idle_cycle(8'($urandom_range(32, 126)));
      end else begin
        r = $urandom_range(0, 99);
        if (r < 62)      c = 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 72) c = "+";
        else if (r < 79) c = "-";
        else if (r < 84) c = "*";
        else if (r < 95) c = "=";
        else if (r < 97) c = "a";
        else             c = " ";
        send(c);
      end
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
